// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encoding and FSM state constants.
package lsu_pkg;

    localparam logic [1:0] SZ_WORD    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_BYTE    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t StIdle   = 2'd0;
    localparam lsu_state_t StAccess = 2'd1;
    localparam lsu_state_t StSplit  = 2'd2;
    localparam lsu_state_t StResp   = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Alignment helper: classifies an incoming request and applies the final load extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_addr_lo,
    input  logic [1:0]  size_q,
    input  logic        signed_q,
    input  logic        split_q,
    input  logic [31:0] raw_data,
    output logic        misaligned,
    output logic [2:0]  beats,
    output logic [31:0] load_data
);

    always_comb begin
        misaligned = ((req_size == SZ_WORD) && (req_addr_lo != 2'b00)) ||
                     ((req_size == SZ_HALF) && req_addr_lo[0]);
        unique case (req_size)
            SZ_WORD: beats = 3'd4;
            SZ_HALF: beats = 3'd2;
            default: beats = 3'd1;
        endcase
    end

    // Aligned loads arrive already extended by the memory; only assembled halves need it here.
    always_comb begin
        load_data = raw_data;
        if (split_q && (size_q == SZ_HALF)) begin
            load_data = signed_q ? {{16{raw_data[15]}}, raw_data[15:0]}
                                 : {16'h0000, raw_data[15:0]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: aligned accesses take one memory cycle, misaligned ones are split into byte beats.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_fetch_phase,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_au_sel,
    output logic              mem_signed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              write_q, signed_q, split_q;
    logic [1:0]        size_q, beat_q, last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, result_q;

    logic              misaligned;
    logic [2:0]        beats;
    logic [31:0]       load_data;
    logic              accept;

    assign accept = (state_q == StIdle) && req_valid;

    lsu_align u_align (
        .req_size    (req_size),
        .req_addr_lo (req_addr[1:0]),
        .size_q      (size_q),
        .signed_q    (signed_q),
        .split_q     (split_q),
        .raw_data    (result_q),
        .misaligned  (misaligned),
        .beats       (beats),
        .load_data   (load_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_size == SZ_ILLEGAL) state_d = StResp;
                    else if (misaligned)        state_d = StSplit;
                    else                        state_d = StAccess;
                end
            end
            StAccess: state_d = StResp;
            StSplit:  if (beat_q == last_q) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            split_q  <= 1'b0;
            size_q   <= SZ_WORD;
            beat_q   <= 2'd0;
            last_q   <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            result_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= req_write;
                signed_q <= req_signed;
                split_q  <= misaligned;
                size_q   <= req_size;
                beat_q   <= 2'd0;
                last_q   <= 2'(beats - 3'd1);
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                result_q <= 32'h0;
            end else if (state_q == StAccess) begin
                if (!write_q) result_q <= mem_rdata;
            end else if (state_q == StSplit) begin
                if (!write_q) result_q[{beat_q, 3'b000} +: 8] <= mem_rdata[7:0];
                beat_q <= (beat_q == last_q) ? 2'd0 : beat_q + 2'd1;
            end
        end
    end

    // All outputs decode from registered state only, so reset forces them immediately.
    always_comb begin
        req_ready       = 1'b0;
        mem_fetch_phase = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_au_sel      = SZ_WORD;
        mem_signed      = 1'b0;
        mem_addr        = '0;
        mem_wdata       = 32'h0;
        rsp_valid       = 1'b0;
        rsp_rdata       = 32'h0;
        rsp_err         = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready       = 1'b1;
                mem_fetch_phase = 1'b1;
            end
            StAccess: begin
                mem_read   = !write_q;
                mem_write  = write_q;
                mem_au_sel = size_q;
                mem_signed = signed_q;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
            end
            StSplit: begin
                mem_read   = !write_q;
                mem_write  = write_q;
                mem_au_sel = SZ_BYTE;
                mem_addr   = addr_q + ADDR_W'(beat_q);
                mem_wdata  = {24'h0, wdata_q[{beat_q, 3'b000} +: 8]};
            end
            StResp: begin
                rsp_valid = 1'b1;
                rsp_err   = (size_q == SZ_ILLEGAL);
                rsp_rdata = (write_q || (size_q == SZ_ILLEGAL)) ? 32'h0 : load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 8: data-memory byte-address width; address arithmetic wraps modulo 2^ADDR_W.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  pipeline MEM stage presents a load/store request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 word, 01 half, 10 byte, 11 illegal.
REQ-008 req_signed  input  1  load sign-extension select (1 = LB/LH, 0 = LBU/LHU).
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, least-significant bytes used for half/byte.
REQ-011 rsp_valid  output  1  one-cycle pulse: request complete.
REQ-012 rsp_rdata  output  32  load result, valid with rsp_valid; 0 for stores and errors.
REQ-013 rsp_err  output  1  valid with rsp_valid; 1 = illegal size.
REQ-014 mem_fetch_phase  output  1  drives the memory fetch/data phase select; 1 = instruction fetch owns the port.
REQ-015 mem_read, mem_write  output  1 each  memory data-phase strobes.
REQ-016 mem_au_sel  output  2  memory access size, same encoding as req_size.
REQ-017 mem_signed  output  1  memory sign-extension select.
REQ-018 mem_addr  output  ADDR_W  memory byte address.
REQ-019 mem_wdata  output  32  memory store data.
REQ-020 mem_rdata  input  32  memory read data, combinational from mem_addr/strobes.

Function
REQ-021 FSM states: IDLE, ACCESS, SPLIT, RESP.
REQ-022 IDLE: req_ready=1, mem_fetch_phase=1, mem_read=mem_write=0; on req_valid, register the request. Go to RESP with rsp_err=1 if size=11. Go to SPLIT if the access is misaligned (word with addr[1:0]!=0, or half with addr[0]=1). Otherwise go to ACCESS.
REQ-023 In every state other than IDLE: req_ready=0 and mem_fetch_phase=0.
REQ-024 ACCESS lasts one cycle and drives the registered size, signed, addr and wdata with mem_read or mem_write asserted. For loads, mem_rdata is captured at the end of the cycle. Next state is RESP.
REQ-025 SPLIT runs N beats (word N=4, half N=2), one byte access per cycle, with beat counter b = 0..N-1. Each beat: mem_addr = addr+b (wraps), mem_au_sel=10, mem_signed=0. Stores drive mem_wdata[7:0] = wdata[8b+7:8b]. Loads capture mem_rdata[7:0] into result byte b.
REQ-026 After beat N-1, go to RESP. For split half loads with req_signed=1, sign-extend from bit 15 of the assembled result; otherwise zero-extend.
REQ-027 RESP lasts exactly one cycle: rsp_valid=1, rsp_rdata/rsp_err driven, no memory strobes. Next state is IDLE.
REQ-028 Latency from the accept edge T: aligned access responds at T+2; split access responds at T+N+1; illegal-size request responds at T+1.
REQ-029 mem_write shall be asserted only in ACCESS/SPLIT cycles of a store. mem_addr and mem_wdata shall be stable for the whole cycle in which mem_write is high.
REQ-030 A request arriving while req_ready=0 is not accepted; the upstream stage holds it (stall).

Reset
REQ-031 While rst_n=0: state=IDLE, beat counter=0, all captured data=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_read=mem_write=0, mem_fetch_phase=1, mem_addr=0, mem_wdata=0, mem_au_sel=00, mem_signed=0.
REQ-032 Reset asserted mid-access aborts the access immediately with no response. No further memory beat is issued; bytes already written remain written.

Structure
REQ-033 Shared package lsu_pkg holds the size encoding constants (SZ_WORD, SZ_HALF, SZ_BYTE, SZ_ILLEGAL) and the FSM state type.
REQ-034 One combinational sub-module, lsu_align, computes the misaligned flag, beat count N, and final load extension.

Verification
REQ-035 Aligned LW from addr 0x04 with mem returning 0x0000_0009 -> single ACCESS cycle, rsp_valid at T+2, rsp_rdata=0x0000_0009, rsp_err=0.
REQ-036 SW of 0xA1B2_C3D4 to addr 0x0D -> 4 byte writes: 0xD4@0x0D, 0xC3@0x0E, 0xB2@0x0F, 0xA1@0x10. rsp_valid at T+5; a subsequent LW from 0x0D returns 0xA1B2_C3D4.
REQ-037 LH from addr 0x0F with bytes 0x80@0x0F and 0xFF@0x10 -> 2 beats, rsp_rdata=0xFFFF_FF80. The same access as LHU -> 0x0000_FF80.
REQ-038 LW from addr 0xFE (ADDR_W=8) -> beats at 0xFE, 0xFF, 0x00, 0x01 (address wraps).
REQ-039 Request with req_size=11 -> no memory strobe, rsp_valid at T+1, rsp_err=1, rsp_rdata=0.
REQ-040 rst_n dropped during beat 2 of a split SW -> outputs at reset values within the same cycle, no beat 3 write, no rsp_valid; the next request after reset completes normally.
